// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: access-size codes
// and the arbiter state encoding.
package mem_port_arbiter_pkg;

   localparam int DMT_W = 3;

   localparam logic [DMT_W-1:0] DMT_WORD  = 3'b000;
   localparam logic [DMT_W-1:0] DMT_HALF  = 3'b001;
   localparam logic [DMT_W-1:0] DMT_HALFU = 3'b010;
   localparam logic [DMT_W-1:0] DMT_BYTE  = 3'b011;
   localparam logic [DMT_W-1:0] DMT_BYTEU = 3'b100;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_FETCH = 2'b01,
      ARB_DATA  = 2'b10
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch is waiting.
module arb_starve_cnt #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CW-1:0] cnt;

   assign sat = (cnt == CW'(STARVE_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one
// single-ported memory with a ready-based handshake.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ARB_IDLE  | no access in flight; one grant decision per cycle
//   ARB_FETCH | fetch access on the memory bus, waiting for mem_ready
//   ARB_DATA  | load/store access on the memory bus, waiting for mem_ready
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [AW-1:0]    if_addr,
   input  logic             if_flush,
   output logic             if_ack,
   output logic [DW-1:0]    if_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [AW-1:0]    d_addr,
   input  logic [DW-1:0]    d_wdata,
   input  logic [DMT_W-1:0] d_dmtype,
   output logic             d_ack,
   output logic [DW-1:0]    d_rdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   output logic [DMT_W-1:0] mem_dmtype,
   input  logic [DW-1:0]    mem_rdata,
   input  logic             mem_ready,
   output logic             stall
);

   arb_state_t state;
   logic       drop;
   logic       hold;
   logic       sat;
   logic       grant_d;
   logic       grant_i;

   // hold marks the ack cycle: the requester is still showing the request it
   // is being acked for, so no grant may be taken from it that cycle.
   always_comb begin
      grant_d = 1'b0;
      grant_i = 1'b0;
      if (state == ARB_IDLE && !hold) begin
         grant_d = d_req & (~sat | ~if_req);
         grant_i = ~grant_d & if_req & ~if_flush;
      end
   end

   arb_starve_cnt #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk(clk),
      .rst(rst),
      .inc(grant_d & if_req),
      .clr(grant_i | (grant_d & ~if_req)),
      .sat(sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ARB_IDLE;
         drop       <= 1'b0;
         hold       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_dmtype <= DMT_WORD;
         if_ack     <= 1'b0;
         d_ack      <= 1'b0;
         if_rdata   <= '0;
         d_rdata    <= '0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            ARB_IDLE: begin
               hold <= 1'b0;
               if (grant_d) begin
                  state      <= ARB_DATA;
                  mem_req    <= 1'b1;
                  mem_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
                  mem_dmtype <= d_dmtype;
               end else if (grant_i) begin
                  state      <= ARB_FETCH;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= if_addr;
                  mem_wdata  <= '0;
                  mem_dmtype <= DMT_WORD;
               end
            end
            ARB_FETCH: begin
               if (mem_ready) begin
                  state   <= ARB_IDLE;
                  mem_req <= 1'b0;
                  hold    <= 1'b1;
                  drop    <= 1'b0;
                  if (!drop && !if_flush) begin
                     if_ack   <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else if (if_flush) begin
                  drop <= 1'b1;
               end
            end
            ARB_DATA: begin
               if (mem_ready) begin
                  state   <= ARB_IDLE;
                  mem_req <= 1'b0;
                  hold    <= 1'b1;
                  d_ack   <= 1'b1;
                  if (!mem_we) begin
                     d_rdata <= mem_rdata;
                  end
               end
            end
            default: begin
               state   <= ARB_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign stall = (if_req & ~if_ack & ~if_flush) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table, directed corner sequences,
// then randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SM = 2;

   logic          clk;
   logic          rst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [2:0]    d_dmtype;
   logic          d_ack;
   logic [DW-1:0] d_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [2:0]    mem_dmtype;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          stall;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_dmtype(d_dmtype), .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_dmtype(mem_dmtype),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: which requester owns the memory, whether the fetch was
   // cancelled, whether this is the ack cycle, and the data-grant streak.
   logic          m_mem_req, m_we, m_if_ack, m_d_ack;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
   logic [2:0]    m_dm;
   int            m_owner;    // 0 none, 1 fetch, 2 data
   logic          m_cancel;
   logic          m_ackcyc;
   int            m_streak;

   always @(posedge clk) begin
      if (rst) begin
         m_mem_req <= 0; m_we <= 0; m_addr <= 0; m_wdata <= 0; m_dm <= 0;
         m_if_ack <= 0; m_d_ack <= 0; m_if_rdata <= 0; m_d_rdata <= 0;
         m_owner <= 0; m_cancel <= 0; m_ackcyc <= 0; m_streak <= 0;
      end else begin
         m_if_ack <= 0;
         m_d_ack  <= 0;
         if (m_owner == 0) begin
            m_ackcyc <= 0;
            if (!m_ackcyc) begin
               if (d_req && (m_streak < SM || !if_req)) begin
                  m_owner <= 2; m_mem_req <= 1; m_we <= d_we; m_addr <= d_addr;
                  m_wdata <= d_wdata; m_dm <= d_dmtype;
                  m_streak <= if_req ? ((m_streak + 1 > SM) ? SM : m_streak + 1) : 0;
               end else if (if_req && !if_flush) begin
                  m_owner <= 1; m_mem_req <= 1; m_we <= 0; m_addr <= if_addr;
                  m_wdata <= 0; m_dm <= 0; m_streak <= 0;
               end
            end
         end else if (mem_ready) begin
            m_mem_req <= 0; m_owner <= 0; m_cancel <= 0; m_ackcyc <= 1;
            if (m_owner == 1) begin
               if (!(m_cancel || if_flush)) begin
                  m_if_ack <= 1; m_if_rdata <= mem_rdata;
               end
            end else begin
               m_d_ack <= 1;
               if (!m_we) m_d_rdata <= mem_rdata;
            end
         end else if (m_owner == 1 && if_flush) begin
            m_cancel <= 1;
         end
      end
   end

   typedef struct {
      logic          rst, ir;
      logic [31:0]   ia;
      logic          fl, dr, dw;
      logic [31:0]   da, dwd;
      logic [2:0]    dm;
      logic          rdy;
      logic [31:0]   rd;
      logic          e_req, e_we;
      logic [31:0]   e_addr, e_wdata;
      logic [2:0]    e_dm;
      logic          e_iack;
      logic [31:0]   e_ird;
      logic          e_dack;
      logic [31:0]   e_drd;
      logic          e_stall;
   } vec_t;

   vec_t tbl[20];

   task automatic apply(input vec_t v);
      rst = v.rst; if_req = v.ir; if_addr = v.ia; if_flush = v.fl;
      d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dwd; d_dmtype = v.dm;
      mem_ready = v.rdy; mem_rdata = v.rd;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   gnt[6];
      int   exp_g[6];
      int   ng, nia, nda;
      logic prev, saw_i, saw_d, done;

      // rst ir ia fl dr dw da dwd dm rdy rd | req we addr wdata dm iack ird dack drd stall
      tbl[0]  = '{1,0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0,0,0};
      tbl[1]  = '{0,1,32'h100,0,0,0,0,0,0,0,0,      0,0,0,0,0,0,0,0,0,1};
      tbl[2]  = '{0,1,32'h100,0,0,0,0,0,0,1,32'h00500093,
                  1,0,32'h100,0,0,0,0,0,0,1};
      tbl[3]  = '{0,1,32'h100,0,0,0,0,0,0,0,0,
                  0,0,32'h100,0,0,1,32'h00500093,0,0,0};
      tbl[4]  = '{0,0,0,0,0,0,0,0,0,0,0,
                  0,0,32'h100,0,0,0,32'h00500093,0,0,0};
      tbl[5]  = '{0,1,32'h104,0,1,1,32'h2000,32'hDEADBEEF,0,0,0,
                  0,0,32'h100,0,0,0,32'h00500093,0,0,1};
      tbl[6]  = '{0,1,32'h104,0,1,1,32'h2000,32'hDEADBEEF,0,1,32'hCAFE0000,
                  1,1,32'h2000,32'hDEADBEEF,0,0,32'h00500093,0,0,1};
      tbl[7]  = '{0,1,32'h104,0,1,1,32'h2000,32'hDEADBEEF,0,0,0,
                  0,1,32'h2000,32'hDEADBEEF,0,0,32'h00500093,1,0,1};
      tbl[8]  = '{0,1,32'h104,0,0,0,0,0,0,0,0,
                  0,1,32'h2000,32'hDEADBEEF,0,0,32'h00500093,0,0,1};
      tbl[9]  = '{0,1,32'h104,0,0,0,0,0,0,1,32'h12345678,
                  1,0,32'h104,0,0,0,32'h00500093,0,0,1};
      tbl[10] = '{0,1,32'h104,0,0,0,0,0,0,0,0,
                  0,0,32'h104,0,0,1,32'h12345678,0,0,0};
      tbl[11] = '{0,0,0,0,0,0,0,0,0,0,0,
                  0,0,32'h104,0,0,0,32'h12345678,0,0,0};
      tbl[12] = '{0,0,0,0,1,0,32'h3002,0,1,0,0,
                  0,0,32'h104,0,0,0,32'h12345678,0,0,1};
      for (int i = 13; i <= 16; i++)
         tbl[i] = '{0,0,0,0,1,0,32'h3002,0,1,0,0,
                    1,0,32'h3002,0,1,0,32'h12345678,0,0,1};
      tbl[17] = '{0,0,0,0,1,0,32'h3002,0,1,1,32'hFFFF8001,
                  1,0,32'h3002,0,1,0,32'h12345678,0,0,1};
      tbl[18] = '{0,0,0,0,1,0,32'h3002,0,1,0,0,
                  0,0,32'h3002,0,1,0,32'h12345678,1,32'hFFFF8001,0};
      tbl[19] = '{0,0,0,0,0,0,0,0,0,0,0,
                  0,0,32'h3002,0,1,0,32'h12345678,0,32'hFFFF8001,0};

      rst = 1; if_req = 0; if_addr = 0; if_flush = 0; d_req = 0; d_we = 0;
      d_addr = 0; d_wdata = 0; d_dmtype = 0; mem_ready = 0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i]);
         @(negedge clk);
         chk($sformatf("vec%0d_mem_req", i),    mem_req,    tbl[i].e_req);
         chk($sformatf("vec%0d_mem_we", i),     mem_we,     tbl[i].e_we);
         chk($sformatf("vec%0d_mem_addr", i),   mem_addr,   tbl[i].e_addr);
         chk($sformatf("vec%0d_mem_wdata", i),  mem_wdata,  tbl[i].e_wdata);
         chk($sformatf("vec%0d_mem_dmtype", i), mem_dmtype, tbl[i].e_dm);
         chk($sformatf("vec%0d_if_ack", i),     if_ack,     tbl[i].e_iack);
         chk($sformatf("vec%0d_if_rdata", i),   if_rdata,   tbl[i].e_ird);
         chk($sformatf("vec%0d_d_ack", i),      d_ack,      tbl[i].e_dack);
         chk($sformatf("vec%0d_d_rdata", i),    d_rdata,    tbl[i].e_drd);
         chk($sformatf("vec%0d_stall", i),      stall,      tbl[i].e_stall);
         step();
      end

      // Starvation: both ports request continuously, memory always ready.
      exp_g = '{1, 1, 0, 1, 1, 0};
      ng = 0; nia = 0; nda = 0; prev = 0; done = 0;
      if_req = 1; if_addr = 32'h0A0; if_flush = 0;
      d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 1; d_dmtype = 0;
      mem_ready = 1; mem_rdata = 32'h55;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (mem_req && !prev && ng < 6) begin
            gnt[ng] = mem_we ? 1 : 0;
            ng++;
         end
         prev  = mem_req;
         saw_i = if_ack;
         saw_d = d_ack;
         if (if_ack) nia++;
         if (d_ack) nda++;
         if (ng == 6 && nia + nda == 6) done = 1;
         step();
         if (saw_i) if_addr = if_addr + 4;
         if (saw_d) begin
            d_addr  = d_addr + 4;
            d_wdata = d_wdata + 1;
         end
      end
      if_req = 0; d_req = 0; mem_ready = 0;
      chk("starve_done", done, 1);
      for (int k = 0; k < 6; k++)
         chk($sformatf("starve_grant%0d_is_data", k), (k < ng) ? gnt[k] : -1, exp_g[k]);
      chk("starve_if_acks", nia, 2);
      chk("starve_d_acks", nda, 4);
      step();

      // Flush mid-fetch; memory completes three cycles after the request.
      if_req = 1; if_addr = 32'h200; mem_rdata = 32'hBAD0BAD0;
      step();
      @(negedge clk);
      chk("flush_req_up", mem_req, 1);
      chk("flush_addr_200", mem_addr, 32'h200);
      step();
      if_flush = 1;
      @(negedge clk);
      chk("flush_stall_low", stall, 0);
      step();
      if_flush = 0; if_addr = 32'h300;
      @(negedge clk);
      chk("flush_addr_held", mem_addr, 32'h200);
      chk("flush_stall_new", stall, 1);
      step();
      mem_ready = 1;
      @(negedge clk);
      chk("flush_req_held", mem_req, 1);
      step();
      mem_ready = 0;
      @(negedge clk);
      chk("flush_no_ack", if_ack, 0);
      chk("flush_req_drop", mem_req, 0);
      chk("flush_rdata_kept", if_rdata, 32'h55);
      step();
      @(negedge clk);
      chk("flush_no_ack2", if_ack, 0);
      step();
      @(negedge clk);
      chk("flush_new_req", mem_req, 1);
      chk("flush_new_addr", mem_addr, 32'h300);
      step();
      mem_ready = 1; mem_rdata = 32'h00000013;
      step();
      mem_ready = 0;
      @(negedge clk);
      chk("flush_new_ack", if_ack, 1);
      chk("flush_new_rdata", if_rdata, 32'h13);
      step();
      if_req = 0;
      step();

      // Reset while a store is on the bus.
      d_req = 1; d_we = 1; d_addr = 32'h5000; d_wdata = 32'h77; d_dmtype = 3'b011;
      step();
      @(negedge clk);
      chk("rst_pre_req", mem_req, 1);
      chk("rst_pre_addr", mem_addr, 32'h5000);
      step();
      rst = 1;
      step();
      rst = 0; d_req = 0;
      @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_dmtype", mem_dmtype, 0);
      chk("rst_if_ack", if_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      step();
      @(negedge clk);
      chk("rst_no_late_ack", d_ack, 0);
      step();
      d_req = 1; d_we = 0; d_addr = 32'h6000; d_dmtype = 0; mem_ready = 1; mem_rdata = 32'hA5A5;
      step();
      @(negedge clk);
      chk("rst_resume_req", mem_req, 1);
      chk("rst_resume_addr", mem_addr, 32'h6000);
      step();
      mem_ready = 0;
      @(negedge clk);
      chk("rst_resume_ack", d_ack, 1);
      chk("rst_resume_rdata", d_rdata, 32'hA5A5);
      step();
      d_req = 0;

      // Randomized traffic against the model.
      rst = 1;
      step();
      rst = 0;
      for (int c = 0; c < 600; c++) begin
         if (if_req && (m_if_ack || if_flush)) if_req = 0;
         if (!if_req && ($urandom % 2 == 0)) begin
            if_req  = 1;
            if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if_flush = ($urandom % 10 == 0);
         if (d_req && m_d_ack) d_req = 0;
         if (!d_req && ($urandom % 2 == 0)) begin
            d_req    = 1;
            d_we     = $urandom % 2;
            d_addr   = $urandom;
            d_wdata  = $urandom;
            d_dmtype = 3'($urandom_range(4, 0));
         end
         mem_ready = ($urandom % 3 != 0);
         mem_rdata = $urandom;
         rst       = ($urandom % 150 == 0);
         @(negedge clk);
         chk("rnd_mem_req", mem_req, m_mem_req);
         chk("rnd_mem_we", mem_we, m_we);
         chk("rnd_mem_addr", mem_addr, m_addr);
         chk("rnd_mem_wdata", mem_wdata, m_wdata);
         chk("rnd_mem_dmtype", mem_dmtype, m_dm);
         chk("rnd_if_ack", if_ack, m_if_ack);
         chk("rnd_if_rdata", if_rdata, m_if_rdata);
         chk("rnd_d_ack", d_ack, m_d_ack);
         chk("rnd_d_rdata", d_rdata, m_d_rdata);
         chk("rnd_stall", stall,
             (if_req & ~m_if_ack & ~if_flush) | (d_req & ~m_d_ack));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
